// File: rtl/shift_pkg.sv
// shift_pkg: shared widths and request types for the shift arbiter slice.
// Contents: SHIFT_W/SHAMT_W constants, requester index type, operand bundle.
// Used by shift_arbiter; left_shifter is width-parameterised on its own.
package shift_pkg;

  localparam int SHIFT_W = 64;
  localparam int SHAMT_W = 6;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] data;
    logic [SHAMT_W-1:0] shamt;
  } shift_req_t;

endpackage

// File: rtl/left_shifter.sv
// left_shifter: combinational logical left barrel shifter, zero fill.
// Ports: data_in/shamt in; data_out, overflow (any stage's MSB differs from
// the operand MSB, stages applied LSB of shamt first) out. No clock, no state.
module left_shifter #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_out,
  output logic               overflow
);

  logic [SHAMT_W:0][WIDTH-1:0] stage;
  logic                        ovf;

  always_comb begin
    stage    = '0;
    ovf      = 1'b0;
    stage[0] = data_in;
    for (int k = 0; k < SHAMT_W; k++) begin
      stage[k+1] = shamt[k] ? (stage[k] << (1 << k)) : stage[k];
      // Sign change observed at any intermediate stage counts, not only the final one.
      ovf = ovf | (stage[k+1][WIDTH-1] ^ data_in[WIDTH-1]);
    end
  end

  assign data_out = stage[SHAMT_W];
  assign overflow = ovf;

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for one shared left_shifter,
// with a one-entry tagged result register (1-cycle latency, 1 result/cycle).
// Ports: clk/rst(async, high)/flush; req{0,1}_{valid,ready,data,shamt};
// rsp_{valid,ready,id,data,ovf}. Macro SHIFT_ARB_OVF_EN enables the rsp_ovf flop.
module shift_arbiter #(
  parameter int WIDTH   = shift_pkg::SHIFT_W,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_ovf
);

  import shift_pkg::*;

  // Result register and round-robin pointer
  logic             rsp_valid_q, rsp_valid_d;
  req_id_t          rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  req_id_t          last_grant_q, last_grant_d;

  shift_req_t       req0_s, req1_s, sel_s;
  logic             grant_vld;
  req_id_t          grant_id;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] shl_out;

  assign req0_s = '{data: req0_data, shamt: req0_shamt};
  assign req1_s = '{data: req1_data, shamt: req1_shamt};

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = '0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // rst term keeps both readies low while reset is asserted.
  assign can_accept = !rst && !flush && (!rsp_valid_q || rsp_ready);
  assign accept     = can_accept && grant_vld;
  assign req0_ready = accept && (grant_id == 1'b0);
  assign req1_ready = accept && (grant_id == 1'b1);

  assign sel_s = grant_id[0] ? req1_s : req0_s;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_data_d   = shl_out;
      last_grant_d = grant_id;
    end else if (flush || rsp_ready) begin
      // Payload is kept on drain/flush; only the valid bit drops.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q[0];
  assign rsp_data  = rsp_data_q;

`ifdef SHIFT_ARB_OVF_EN
  logic shl_ovf;
  logic rsp_ovf_q, rsp_ovf_d;

  left_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shl (
    .data_in  (sel_s.data),
    .shamt    (sel_s.shamt),
    .data_out (shl_out),
    .overflow (shl_ovf)
  );

  assign rsp_ovf_d = accept ? shl_ovf : rsp_ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_ovf_q <= 1'b0;
    end else begin
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  // Overflow output goes nowhere in this build.
  logic shl_ovf_unused;

  left_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shl (
    .data_in  (sel_s.data),
    .shamt    (sel_s.shamt),
    .data_out (shl_out),
    .overflow (shl_ovf_unused)
  );

  assign rsp_ovf = 1'b0;
`endif

endmodule
